// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : main control FSM of the multi-cycle RV64 core
// Optional perf counters via `MULTICYCLE_CTRL_PERF_EN.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] ctrl_ALU_op,
    output logic       alu_src,
    output logic       addr_sel,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       halted
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] c_CLS_R     = 2'd0;
    localparam logic [1:0] c_CLS_LOAD  = 2'd1;
    localparam logic [1:0] c_CLS_STORE = 2'd2;
    localparam logic [1:0] c_CLS_BEQ   = 2'd3;

    state_t     state_q, state_d;
    logic [1:0] cls_q, cls_d;
    logic [1:0] dec_cls;
    logic       dec_legal;

    always_comb begin
        dec_cls   = c_CLS_R;
        dec_legal = 1'b1;
        case (opcode)
            7'b0110011: dec_cls = c_CLS_R;
            7'b0000011: dec_cls = c_CLS_LOAD;
            7'b0100011: dec_cls = c_CLS_STORE;
            7'b1100011: dec_cls = c_CLS_BEQ;
            default:    dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        ctrl_ALU_op = 2'b00;
        alu_src     = 1'b0;
        addr_sel    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                cls_d   = dec_cls;
                state_d = dec_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                case (cls_q)
                    c_CLS_R: begin
                        ctrl_ALU_op = 2'b10;
                        state_d     = S_WB;
                    end
                    c_CLS_BEQ: begin
                        ctrl_ALU_op = 2'b01;
                        branch      = 1'b1;
                        state_d     = S_FETCH;
                    end
                    default: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                endcase
            end
            S_MEM: begin
                addr_sel = 1'b1;
                alu_src  = 1'b1;
                // Only load/store classes can reach MEM
                if (cls_q == c_CLS_STORE) begin
                    mem_write = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == c_CLS_LOAD);
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic        retire;
    logic [63:0] cycle_cnt_q, instret_cnt_q;

    assign retire = (state_q == S_WB)
                  | ((state_q == S_MEM) && (cls_q == c_CLS_STORE) && mem_ready)
                  | ((state_q == S_EXEC) && (cls_q == c_CLS_BEQ));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q   <= 64'd0;
            instret_cnt_q <= 64'd0;
        end else begin
            if (state_q != S_HALT) cycle_cnt_q <= cycle_cnt_q + 64'd1;
            if (retire) instret_cnt_q <= instret_cnt_q + 64'd1;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : directed self-checking bench for multicycle_ctrl
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic [1:0] ctrl_ALU_op;
    logic       alu_src, addr_sel, mem_read, mem_write, ir_write, pc_write;
    logic       branch, reg_write, mem_to_reg, halted;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    multicycle_ctrl u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .ctrl_ALU_op (ctrl_ALU_op),
        .alu_src     (alu_src),
        .addr_sel    (addr_sel),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .branch      (branch),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .halted      (halted)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ALU_op[1:0], alu_src, addr_sel, mem_read, mem_write, ir_write, pc_write,
    //  branch, reg_write, mem_to_reg, halted}
    logic [11:0] obs;
    assign obs = {ctrl_ALU_op, alu_src, addr_sel, mem_read, mem_write,
                  ir_write, pc_write, branch, reg_write, mem_to_reg, halted};

    localparam logic [11:0] c_FETCH_RDY = 12'b00_0_0_1_0_1_1_0_0_0_0;
    localparam logic [11:0] c_FETCH_WT  = 12'b00_0_0_1_0_0_0_0_0_0_0;
    localparam logic [11:0] c_DECODE    = 12'b00_0_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] c_EX_R      = 12'b10_0_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] c_EX_LS     = 12'b00_1_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] c_EX_BEQ    = 12'b01_0_0_0_0_0_0_1_0_0_0;
    localparam logic [11:0] c_MEM_LD    = 12'b00_1_1_1_0_0_0_0_0_0_0;
    localparam logic [11:0] c_MEM_ST    = 12'b00_1_1_0_1_0_0_0_0_0_0;
    localparam logic [11:0] c_WB_R      = 12'b00_0_0_0_0_0_0_0_1_0_0;
    localparam logic [11:0] c_WB_LD     = 12'b00_0_0_0_0_0_0_0_1_1_0;
    localparam logic [11:0] c_HALT      = 12'b00_0_0_0_0_0_0_0_0_0_1;

    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_LD  = 7'b0000011;
    localparam logic [6:0] c_OP_ST  = 7'b0100011;
    localparam logic [6:0] c_OP_BEQ = 7'b1100011;
    localparam logic [6:0] c_OP_ILL = 7'b1111111;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive inputs, check this cycle's outputs, advance one cycle.
    task automatic cyc(input string tag, input logic rst, input logic rdy,
                       input logic [6:0] op, input logic [11:0] exp);
        rst_n     = rst;
        mem_ready = rdy;
        opcode    = op;
        #1;
        check_eq(tag, {52'd0, obs}, {52'd0, exp});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_fetch", {52'd0, obs}, {52'd0, c_FETCH_RDY});
`ifdef MULTICYCLE_CTRL_PERF_EN
        check_eq("reset_cycle_cnt", cycle_cnt, 64'd0);
        check_eq("reset_instret", instret_cnt, 64'd0);
`endif

        // R-type, zero wait: 4 cycles
        cyc("r_fetch",  1, 1, c_OP_R, c_FETCH_RDY);
        cyc("r_decode", 1, 1, c_OP_R, c_DECODE);
        cyc("r_exec",   1, 1, c_OP_R, c_EX_R);
        cyc("r_wb",     1, 1, c_OP_R, c_WB_R);
        // LOAD, zero wait: 5 cycles
        cyc("ld0_fetch",  1, 1, c_OP_LD, c_FETCH_RDY);
        cyc("ld0_decode", 1, 1, c_OP_LD, c_DECODE);
        cyc("ld0_exec",   1, 1, c_OP_LD, c_EX_LS);
        cyc("ld0_mem",    1, 1, c_OP_LD, c_MEM_LD);
        cyc("ld0_wb",     1, 1, c_OP_LD, c_WB_LD);
        // STORE then BEQ, zero wait: 4 + 3 cycles
        cyc("st_fetch",   1, 1, c_OP_ST, c_FETCH_RDY);
        cyc("st_decode",  1, 1, c_OP_ST, c_DECODE);
        cyc("st_exec",    1, 1, c_OP_ST, c_EX_LS);
        cyc("st_mem",     1, 1, c_OP_ST, c_MEM_ST);
        cyc("beq_fetch",  1, 1, c_OP_BEQ, c_FETCH_RDY);
        cyc("beq_decode", 1, 1, c_OP_BEQ, c_DECODE);
        cyc("beq_exec",   1, 1, c_OP_BEQ, c_EX_BEQ);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check_eq("perf_cycle_cnt", cycle_cnt, 64'd16);
        check_eq("perf_instret", instret_cnt, 64'd4);
`endif

        // Fetch wait then LOAD with 3 MEM wait cycles: 8 cycles after fetch completes
        cyc("fetch_wait", 1, 0, c_OP_LD, c_FETCH_WT);
        cyc("ldw_fetch",  1, 1, c_OP_LD, c_FETCH_RDY);
        cyc("ldw_decode", 1, 1, c_OP_LD, c_DECODE);
        cyc("ldw_exec",   1, 1, c_OP_LD, c_EX_LS);
        for (int i = 0; i < 3; i++) cyc("ldw_mem_stall", 1, 0, c_OP_LD, c_MEM_LD);
        cyc("ldw_mem_done", 1, 1, c_OP_LD, c_MEM_LD);
        cyc("ldw_wb",       1, 1, c_OP_LD, c_WB_LD);

        // STORE stalling in MEM, abandoned by reset
        cyc("rst_fetch",  1, 1, c_OP_ST, c_FETCH_RDY);
        cyc("rst_decode", 1, 1, c_OP_ST, c_DECODE);
        cyc("rst_exec",   1, 1, c_OP_ST, c_EX_LS);
        cyc("rst_stall",  1, 0, c_OP_ST, c_MEM_ST);
        cyc("rst_edge",   0, 1, c_OP_ST, c_MEM_ST);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check_eq("rst_cycle_cnt", cycle_cnt, 64'd0);
        check_eq("rst_instret", instret_cnt, 64'd0);
`endif

        // Illegal opcode traps in HALT until reset
        cyc("ill_fetch",  1, 1, c_OP_ILL, c_FETCH_RDY);
        cyc("ill_decode", 1, 1, c_OP_ILL, c_DECODE);
        for (int i = 0; i < 20; i++)
            cyc("halt_hold", 1, i[0], (i[1] ? c_OP_R : c_OP_ILL), c_HALT);
`ifdef MULTICYCLE_CTRL_PERF_EN
        check_eq("halt_cycle_cnt", cycle_cnt, 64'd2);
        check_eq("halt_instret", instret_cnt, 64'd0);
`endif
        cyc("halt_rst", 0, 1, c_OP_R, c_HALT);
        cyc("post_halt_fetch", 1, 0, c_OP_R, c_FETCH_WT);
        cyc("post_halt_fetch_rdy", 1, 1, c_OP_R, c_FETCH_RDY);
        cyc("post_halt_decode", 1, 1, c_OP_R, c_DECODE);
        cyc("post_halt_exec", 1, 1, c_OP_R, c_EX_R);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control FSM for the 64-bit RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives `ctrl_ALU_op` into the ALU control decoder. It also drives the register-file, memory and PC/IR enables. It sits between the instruction register (opcode source) and the datapath, and handshakes with the memory port through `mem_ready`.

## Interface
- No parameters.
- `clk`  input  1  core clock; all state changes on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `opcode`  input  7  IR[6:0]; valid from DECODE onward.
- `mem_ready`  input  1  memory completes the current read/write this cycle.
- `ctrl_ALU_op`  output  2  00 = add (load/store), 01 = sub (branch), 10 = R-type funct decode.
- `alu_src`  output  1  0 = rs2, 1 = immediate.
- `addr_sel`  output  1  memory address: 0 = PC, 1 = ALU result.
- `mem_read`  output  1  memory read request.
- `mem_write`  output  1  memory write request.
- `ir_write`  output  1  load IR from memory data.
- `pc_write`  output  1  PC <= PC + 4.
- `branch`  output  1  PC <= branch target if ALU zero.
- `reg_write`  output  1  register file write enable.
- `mem_to_reg`  output  1  writeback source: 0 = ALU, 1 = memory data.
- `halted`  output  1  illegal opcode trapped; sticky until reset.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free.
- Instruction classes, latched in DECODE into a 2-bit class register:
  - R = 0110011
  - LOAD = 0000011
  - STORE = 0100011
  - BEQ = 1100011
  - Anything else is illegal.
- **FETCH**
  - Outputs: `mem_read` = 1, `addr_sel` = 0.
  - `ir_write` = `pc_write` = `mem_ready`. These are Mealy outputs.
  - Stays in FETCH while `mem_ready` = 0; goes to DECODE when it is 1.
- **DECODE**
  - No enables asserted.
  - Legal opcode → EXEC. Illegal opcode → HALT.
- **EXEC**
  - R: `ctrl_ALU_op` = 10, `alu_src` = 0 → WB.
  - LOAD/STORE: `ctrl_ALU_op` = 00, `alu_src` = 1 → MEM.
  - BEQ: `ctrl_ALU_op` = 01, `alu_src` = 0, `branch` = 1 → FETCH.
- **MEM**
  - Common: `addr_sel` = 1, `ctrl_ALU_op` = 00, `alu_src` = 1.
  - LOAD: `mem_read` = 1; on `mem_ready` → WB.
  - STORE: `mem_write` = 1; on `mem_ready` → FETCH.
  - Holds in MEM while `mem_ready` = 0, with all outputs stable.
- **WB**
  - `reg_write` = 1, `mem_to_reg` = 1 if the class is LOAD, else 0 → FETCH.
- **HALT**
  - All enables are 0 and `halted` = 1.
  - There is no exit except reset.
- Every output not listed for a state is 0 in that state; `ctrl_ALU_op` defaults to 00.
- `mem_read` and `mem_write` are never asserted in the same cycle.
- `mem_ready` is ignored outside FETCH and MEM.

## Timing
- Reset: `rst_n` = 0 at an edge puts the FSM in FETCH and clears the class register (and the counters, when built in).
  - Reset wins over every other event.
  - Mid-instruction reset (including during a MEM stall) abandons the instruction; no write enable is asserted after that edge.
- Output values after reset (FETCH state):
  - `mem_read` = 1, `addr_sel` = 0.
  - `ir_write` = `pc_write` = `mem_ready`.
  - All other outputs 0, `halted` = 0.
- Latency with zero-wait memory (`mem_ready` held at 1):
  - BEQ: 3 cycles.
  - R: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- Outputs are combinational from the state, the class register and `mem_ready`. There are no added pipeline registers.

## Configuration
- Macro: `MULTICYCLE_CTRL_PERF_EN`.
- Defined:
  - Adds output `cycle_cnt` [63:0]: increments on every non-reset edge while not HALT.
  - Adds output `instret_cnt` [63:0]: increments on each retiring transition:
    - WB→FETCH
    - MEM→FETCH for a store
    - EXEC→FETCH for a branch
  - Both counters wrap from all-ones to 0 and reset to 0.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Test plan
- Reset with `rst_n` = 0 for 2 cycles, `mem_ready` = 1 → state FETCH, `mem_read` = 1, `ir_write` = `pc_write` = 1, `reg_write` = `mem_write` = 0, `halted` = 0.
- R-type (opcode 0110011), `mem_ready` = 1 → EXEC shows `ctrl_ALU_op` = 10, `alu_src` = 0; `reg_write` = 1 with `mem_to_reg` = 0 on cycle 4; FETCH on cycle 5.
- Load (0000011) with `mem_ready` low for 3 MEM cycles → `mem_read` = 1 and `addr_sel` = 1 held stable for 4 cycles; then WB with `mem_to_reg` = 1; 8 cycles total.
- Store (0100011) followed by BEQ (1100011) → store has `mem_write` = 1 for exactly 1 cycle and no `reg_write`; BEQ EXEC shows `ctrl_ALU_op` = 01, `branch` = 1; back-to-back total 7 cycles.
- Illegal opcode 1111111 → HALT after DECODE, `halted` = 1 for 20 cycles with all enables 0; `rst_n` pulse clears it to FETCH.
- With `MULTICYCLE_CTRL_PERF_EN` defined: run R, LOAD, STORE, BEQ at zero wait → `instret_cnt` = 4, `cycle_cnt` = 16; reset during a MEM stall → both counters 0, FETCH next.
